// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: owns the PC, issues synchronous reads to instruction memory
// and feeds decode through a valid/ready port backed by a 2-entry (out + skid) buffer.
module instruction_fetch_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
    parameter int PC_STEP = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic [ADDR_WIDTH-1:0] read_addr,
    output logic                  read_en,
    input  logic [31:0]           instruction,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    input  logic                  halt,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_instr,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic                  halted
);
    typedef enum logic [1:0] {BOOT, RUN, HALTED} state_t;
    state_t state, state_nx;
    logic [ADDR_WIDTH-1:0] pc, pending_pc, skid_pc;
    logic [31:0] skid_instr;
    logic pending, skid_valid, accept, out_free;
    logic [1:0] occupancy;
    assign read_addr = pc;
    // Occupancy nets out a same-cycle accept so a full-rate stream keeps issuing.
    always_comb begin
        accept    = out_valid && out_ready;
        out_free  = !out_valid || accept;
        occupancy = 2'(out_valid) + 2'(skid_valid) + 2'(pending) - 2'(accept);
        read_en   = state == RUN && !halt && !redirect_valid && occupancy < 2'd2;
        halted    = state == HALTED && !pending;
        state_nx  = state == BOOT ? RUN :
                    state == RUN  ? ((halt && !pending) ? HALTED : RUN) :
                    (halt ? HALTED : RUN);
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= BOOT;
        else
            state <= state_nx;
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc         <= RESET_PC;
            pending    <= 1'b0;
            pending_pc <= '0;
            out_valid  <= 1'b0;
            out_instr  <= '0;
            out_pc     <= '0;
            skid_valid <= 1'b0;
            skid_instr <= '0;
            skid_pc    <= '0;
        end else if (redirect_valid) begin
            pc         <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
            pending    <= 1'b0;
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else begin
            pending <= read_en;
            if (read_en) begin
                pc         <= pc + ADDR_WIDTH'(PC_STEP);
                pending_pc <= pc;
            end
            // The returning word goes to whichever slot is free after this edge's pop.
            if (out_free && skid_valid) begin
                out_valid  <= 1'b1;
                out_instr  <= skid_instr;
                out_pc     <= skid_pc;
                skid_valid <= pending;
                if (pending) begin
                    skid_instr <= instruction;
                    skid_pc    <= pending_pc;
                end
            end else if (out_free) begin
                out_valid <= pending;
                if (pending) begin
                    out_instr <= instruction;
                    out_pc    <= pending_pc;
                end
            end else if (pending) begin
                skid_valid <= 1'b1;
                skid_instr <= instruction;
                skid_pc    <= pending_pc;
            end
        end
    end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: cycle-by-cycle directed vectors covering stream, backpressure,
// redirect, halt/resume, PC wrap and mid-stream asynchronous reset.
module tb_instruction_fetch_unit;
    logic        clock, reset;
    logic [31:0] read_addr;
    logic        read_en;
    logic [31:0] instruction;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        halted;
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        rv;
        logic [31:0] rpc;
        logic        h;
        logic        rdy;
        logic        ev;
        logic [31:0] epc;
        logic        ere;
        logic [31:0] eaddr;
        logic        ehalted;
    } vec_t;
    vec_t vecs[33];

    instruction_fetch_unit dut (
        .clock(clock), .reset(reset), .read_addr(read_addr), .read_en(read_en),
        .instruction(instruction), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .halt(halt), .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .halted(halted)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory word i holds A000_0000 + i, read synchronously.
    always_ff @(posedge clock)
        if (read_en)
            instruction <= 32'hA000_0000 + (read_addr >> 2);

    function automatic vec_t v(logic rv, logic [31:0] rpc, logic h, logic rdy,
                               logic ev, logic [31:0] epc, logic ere, logic [31:0] ea, logic eh);
        vec_t r;
        r.rv = rv; r.rpc = rpc; r.h = h; r.rdy = rdy;
        r.ev = ev; r.epc = epc; r.ere = ere; r.eaddr = ea; r.ehalted = eh;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int i);
        redirect_valid = vecs[i].rv;
        redirect_pc    = vecs[i].rpc;
        halt           = vecs[i].h;
        out_ready      = vecs[i].rdy;
        @(negedge clock);
        chk($sformatf("c%0d out_valid", i), 32'(out_valid), 32'(vecs[i].ev));
        if (vecs[i].ev) begin
            chk($sformatf("c%0d out_pc", i), out_pc, vecs[i].epc);
            chk($sformatf("c%0d out_instr", i), out_instr, 32'hA000_0000 + (vecs[i].epc >> 2));
        end
        chk($sformatf("c%0d read_en", i), 32'(read_en), 32'(vecs[i].ere));
        chk($sformatf("c%0d read_addr", i), read_addr, vecs[i].eaddr);
        chk($sformatf("c%0d halted", i), 32'(halted), 32'(vecs[i].ehalted));
        @(posedge clock);
        #1;
    endtask

    initial begin
        //            rv  rpc           h  rdy ev  epc           re  addr          halted
        vecs[0]  = v(0, 0,             0, 1,  0, 0,            0, 32'h0,        0);
        vecs[1]  = v(0, 0,             0, 1,  0, 0,            1, 32'h0,        0);
        vecs[2]  = v(0, 0,             0, 1,  0, 0,            1, 32'h4,        0);
        vecs[3]  = v(0, 0,             0, 1,  1, 32'h0,        1, 32'h8,        0);
        vecs[4]  = v(0, 0,             0, 1,  1, 32'h4,        1, 32'hC,        0);
        vecs[5]  = v(0, 0,             0, 0,  1, 32'h8,        0, 32'h10,       0);
        vecs[6]  = v(0, 0,             0, 0,  1, 32'h8,        0, 32'h10,       0);
        vecs[7]  = v(0, 0,             0, 0,  1, 32'h8,        0, 32'h10,       0);
        vecs[8]  = v(0, 0,             0, 0,  1, 32'h8,        0, 32'h10,       0);
        vecs[9]  = v(0, 0,             0, 0,  1, 32'h8,        0, 32'h10,       0);
        vecs[10] = v(0, 0,             0, 1,  1, 32'h8,        1, 32'h10,       0);
        vecs[11] = v(0, 0,             0, 1,  1, 32'hC,        1, 32'h14,       0);
        vecs[12] = v(0, 0,             0, 1,  1, 32'h10,       1, 32'h18,       0);
        vecs[13] = v(1, 32'h102,       0, 1,  1, 32'h14,       0, 32'h1C,       0);
        vecs[14] = v(0, 0,             0, 1,  0, 0,            1, 32'h100,      0);
        vecs[15] = v(0, 0,             0, 1,  0, 0,            1, 32'h104,      0);
        vecs[16] = v(0, 0,             0, 1,  1, 32'h100,      1, 32'h108,      0);
        vecs[17] = v(0, 0,             0, 1,  1, 32'h104,      1, 32'h10C,      0);
        vecs[18] = v(0, 0,             1, 1,  1, 32'h108,      0, 32'h110,      0);
        vecs[19] = v(0, 0,             1, 1,  1, 32'h10C,      0, 32'h110,      0);
        vecs[20] = v(0, 0,             1, 1,  0, 0,            0, 32'h110,      1);
        vecs[21] = v(0, 0,             1, 1,  0, 0,            0, 32'h110,      1);
        vecs[22] = v(0, 0,             0, 1,  0, 0,            0, 32'h110,      1);
        vecs[23] = v(0, 0,             0, 1,  0, 0,            1, 32'h110,      0);
        vecs[24] = v(0, 0,             0, 1,  0, 0,            1, 32'h114,      0);
        vecs[25] = v(0, 0,             0, 1,  1, 32'h110,      1, 32'h118,      0);
        vecs[26] = v(1, 32'hFFFF_FFF8, 0, 1,  1, 32'h114,      0, 32'h11C,      0);
        vecs[27] = v(0, 0,             0, 1,  0, 0,            1, 32'hFFFF_FFF8, 0);
        vecs[28] = v(0, 0,             0, 1,  0, 0,            1, 32'hFFFF_FFFC, 0);
        vecs[29] = v(0, 0,             0, 1,  1, 32'hFFFF_FFF8, 1, 32'h0,       0);
        vecs[30] = v(0, 0,             0, 1,  1, 32'hFFFF_FFFC, 1, 32'h4,       0);
        vecs[31] = v(0, 0,             0, 1,  1, 32'h0,        1, 32'h8,        0);
        vecs[32] = v(0, 0,             0, 1,  1, 32'h4,        1, 32'hC,        0);
        reset = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        halt = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset read_en", 32'(read_en), 32'd0);
        chk("reset out_pc", out_pc, 32'd0);
        chk("reset out_instr", out_instr, 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 33; i++)
            run_vec(i);
        chk("pre-reset out_valid", 32'(out_valid), 32'd1);
        chk("pre-reset out_pc", out_pc, 32'h8);
        #2;
        reset = 1'b1;
        #1;
        chk("async reset out_valid", 32'(out_valid), 32'd0);
        chk("async reset read_addr", read_addr, 32'h0);
        chk("async reset read_en", 32'(read_en), 32'd0);
        chk("async reset halted", 32'(halted), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 5; i++)
            run_vec(i);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
